// File: rtl/pll_lock_reset_seq.sv
// ============================================================================
// Module   : pll_lock_reset_seq
// Purpose  : Per-domain PLL-lock reset sequencer with staged video/core
//            release and saturating lock-loss counter.
//            Optional macro PLL_SOFT_RESET_EN adds the soft_rst_req input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_lock_reset_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
`ifdef PLL_SOFT_RESET_EN
    input  logic             soft_rst_req,
`endif
    output logic             rst_video_n,
    output logic             rst_core_n,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int TIMER_MAX = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int TIMER_W   = $clog2(TIMER_MAX);

    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_VID_UP    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rst_video_n_q, rst_video_n_d;
    logic                   rst_core_n_q, rst_core_n_d;
    logic                   ready_q, ready_d;
    logic                   lock_s;
    logic                   soft_req;

`ifdef PLL_SOFT_RESET_EN
    assign soft_req = soft_rst_req;
`else
    assign soft_req = 1'b0;
`endif

    // Raw pll_locked is only ever sampled by the first synchroniser flop.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TIMER_W'(1);
        cnt_d   = cnt_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (!lock_s)                   state_d = ST_WAIT_LOCK;
                else if (soft_req)             timer_d = '0;
                else if (timer_q == STABLE_LAST) state_d = ST_VID_UP;
            end
            ST_VID_UP: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                end else if (soft_req) begin
                    state_d = ST_STABLE;
                end else if (timer_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                end else if (soft_req) begin
                    state_d = ST_STABLE;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Timer only runs in STABLE/VID_UP and restarts on every transition.
        if (state_d != state_q || state_q == ST_WAIT_LOCK || state_q == ST_RUN)
            timer_d = '0;

        rst_video_n_d = (state_d == ST_VID_UP) || (state_d == ST_RUN);
        rst_core_n_d  = (state_d == ST_RUN);
        ready_d       = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            state_q       <= ST_WAIT_LOCK;
            timer_q       <= '0;
            cnt_q         <= '0;
            rst_video_n_q <= 1'b0;
            rst_core_n_q  <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            rst_video_n_q <= rst_video_n_d;
            rst_core_n_q  <= rst_core_n_d;
            ready_q       <= ready_d;
        end
    end

    assign rst_video_n   = rst_video_n_q;
    assign rst_core_n    = rst_core_n_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_reset_seq.sv
// ============================================================================
// Module   : tb_pll_lock_reset_seq
// Purpose  : Directed self-checking bench for pll_lock_reset_seq
//            (SYNC_STAGES=2, STABLE_CYCLES=16, STAGE_GAP=4, CNT_W=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_reset_seq;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pll_locked = 1'b0;
`ifdef PLL_SOFT_RESET_EN
    logic             soft_rst_req = 1'b0;
`endif
    logic             rst_video_n;
    logic             rst_core_n;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    pll_lock_reset_seq #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(16),
        .STAGE_GAP    (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
`ifdef PLL_SOFT_RESET_EN
        .soft_rst_req (soft_rst_req),
`endif
        .rst_video_n  (rst_video_n),
        .rst_core_n   (rst_core_n),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Expects state WAIT_LOCK with an empty sync chain and pll_locked just
    // risen between "edge 0" and "edge 1"; consumes edges 1..23.
    task automatic test_lock_sequence(input string tag);
        ticks(18);
        n_cmp++; if (rst_video_n !== 1'b0) begin n_err++; $display("FAIL %s video_early: got %b want 0", tag, rst_video_n); end
        tick();
        n_cmp++; if (rst_video_n !== 1'b1) begin n_err++; $display("FAIL %s video_up: got %b want 1", tag, rst_video_n); end
        n_cmp++; if (rst_core_n !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL %s core_in_vid: got core=%b ready=%b want 0/0", tag, rst_core_n, ready); end
        ticks(3);
        n_cmp++; if (rst_core_n !== 1'b0) begin n_err++; $display("FAIL %s core_early: got %b want 0", tag, rst_core_n); end
        tick();
        n_cmp++; if (rst_core_n !== 1'b1 || ready !== 1'b1) begin n_err++; $display("FAIL %s run: got core=%b ready=%b want 1/1", tag, rst_core_n, ready); end
        n_cmp++; if (lock_loss_cnt !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL %s cnt: got %0d want %0d", tag, lock_loss_cnt, exp_cnt); end
    endtask

    // From RUN: drop pll_locked before edge k, resets must fall after edge k+2.
    task automatic lose_lock(input string tag);
        ticks(2);
        pll_locked = 1'b0;
        tick();
        n_cmp++; if (rst_video_n !== 1'b1) begin n_err++; $display("FAIL %s loss_k: got video=%b want 1", tag, rst_video_n); end
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL %s loss_k1: got ready=%b want 1", tag, ready); end
        tick();
        if (exp_cnt < CNT_MAX) exp_cnt++;
        n_cmp++; if ({rst_video_n, rst_core_n, ready} !== 3'b000) begin n_err++; $display("FAIL %s loss_k2: got %b%b%b want 000", tag, rst_video_n, rst_core_n, ready); end
        n_cmp++; if (lock_loss_cnt !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL %s loss_cnt: got %0d want %0d", tag, lock_loss_cnt, exp_cnt); end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        ticks(3);
        n_cmp++; if ({rst_video_n, rst_core_n, ready} !== 3'b000) begin n_err++; $display("FAIL reset_outs: got %b%b%b want 000", rst_video_n, rst_core_n, ready); end
        n_cmp++; if (lock_loss_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", lock_loss_cnt); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (rst_video_n !== 1'b0) begin n_err++; $display("FAIL reset_edge0: got video=%b want 0", rst_video_n); end
        pll_locked = 1'b1;
        test_lock_sequence("powerup");
    endtask

    task automatic test_lock_loss();
        lose_lock("loss");
        pll_locked = 1'b1;
        test_lock_sequence("relock");
    endtask

    task automatic test_glitch();
        bit bad;
        lose_lock("glitch_pre");
        ticks(2);
        bad = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) pll_locked = 1'b0;
            tick();
            if (rst_video_n !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL glitch_video: got released=%b want 0", bad); end
        n_cmp++; if (lock_loss_cnt !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL glitch_cnt: got %0d want %0d", lock_loss_cnt, exp_cnt); end
        pll_locked = 1'b1;
        test_lock_sequence("glitch_relock");
    endtask

`ifdef PLL_SOFT_RESET_EN
    task automatic test_soft_reset();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_cmp++; if ({rst_video_n, rst_core_n, ready} !== 3'b000) begin n_err++; $display("FAIL soft_low: got %b%b%b want 000", rst_video_n, rst_core_n, ready); end
        ticks(15);
        n_cmp++; if (rst_video_n !== 1'b0) begin n_err++; $display("FAIL soft_video_early: got %b want 0", rst_video_n); end
        tick();
        n_cmp++; if (rst_video_n !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL soft_video_up: got video=%b ready=%b want 1/0", rst_video_n, ready); end
        ticks(3);
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL soft_ready_early: got %b want 0", ready); end
        tick();
        n_cmp++; if (ready !== 1'b1 || rst_core_n !== 1'b1) begin n_err++; $display("FAIL soft_run: got ready=%b core=%b want 1/1", ready, rst_core_n); end
        n_cmp++; if (lock_loss_cnt !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL soft_cnt: got %0d want %0d", lock_loss_cnt, exp_cnt); end

        // Soft request on the same edge that observes the lock loss.
        ticks(2);
        pll_locked = 1'b0;
        ticks(2);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        if (exp_cnt < CNT_MAX) exp_cnt++;
        n_cmp++; if ({rst_video_n, rst_core_n, ready} !== 3'b000) begin n_err++; $display("FAIL soft_loss_outs: got %b%b%b want 000", rst_video_n, rst_core_n, ready); end
        n_cmp++; if (lock_loss_cnt !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL soft_loss_cnt: got %0d want %0d", lock_loss_cnt, exp_cnt); end
        ticks(3);
        pll_locked = 1'b1;
        test_lock_sequence("soft_relock");
    endtask
`endif

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            lose_lock("sat");
            pll_locked = 1'b1;
            test_lock_sequence("sat_relock");
        end
        n_cmp++; if (lock_loss_cnt !== 2'd3) begin n_err++; $display("FAIL sat_final: got %0d want 3", lock_loss_cnt); end
    endtask

    task automatic test_async_reset();
        lose_lock("areset_pre");
        pll_locked = 1'b1;
        ticks(20);
        n_cmp++; if (rst_video_n !== 1'b1 || rst_core_n !== 1'b0) begin n_err++; $display("FAIL areset_vid_up: got video=%b core=%b want 1/0", rst_video_n, rst_core_n); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({rst_video_n, rst_core_n, ready} !== 3'b000) begin n_err++; $display("FAIL areset_outs: got %b%b%b want 000", rst_video_n, rst_core_n, ready); end
        n_cmp++; if (lock_loss_cnt !== '0) begin n_err++; $display("FAIL areset_cnt: got %0d want 0", lock_loss_cnt); end
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        test_lock_sequence("areset_restart");
    endtask

    initial begin
        test_reset();
        test_lock_loss();
        test_glitch();
`ifdef PLL_SOFT_RESET_EN
        test_soft_reset();
`endif
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
